// File: rtl/obi_pkg.sv
// Shared types and constants for the OBI interconnect blocks (muxes, demuxes, ID FIFOs).
package obi_pkg;

    typedef logic mgr_id_t;

    localparam int OBI_ADDR_WIDTH = 32;
    localparam int OBI_DATA_WIDTH = 32;

    // Pointer width for a FIFO of the given depth; never narrower than one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/obi_id_fifo.sv
// In-order ID FIFO: remembers which manager owns each outstanding transaction.
module obi_id_fifo
    import obi_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            // A simultaneous push and pop leaves the occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/obi_mux_2_to_1.sv
// Two OBI managers onto one subordinate: round-robin address arbitration and
// in-order response routing through an ID FIFO.
module obi_mux_2_to_1
    import obi_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int ADDR_WIDTH      = OBI_ADDR_WIDTH,
    parameter int DATA_WIDTH      = OBI_DATA_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    mgr0_req_i,
    output logic                    mgr0_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   mgr0_addr_i,
    input  logic                    mgr0_we_i,
    input  logic [DATA_WIDTH/8-1:0] mgr0_be_i,
    input  logic [DATA_WIDTH-1:0]   mgr0_wdata_i,
    output logic                    mgr0_rvalid_o,
    output logic [DATA_WIDTH-1:0]   mgr0_rdata_o,
    input  logic                    mgr1_req_i,
    output logic                    mgr1_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   mgr1_addr_i,
    input  logic                    mgr1_we_i,
    input  logic [DATA_WIDTH/8-1:0] mgr1_be_i,
    input  logic [DATA_WIDTH-1:0]   mgr1_wdata_i,
    output logic                    mgr1_rvalid_o,
    output logic [DATA_WIDTH-1:0]   mgr1_rdata_o,
    output logic                    sub_req_o,
    input  logic                    sub_gnt_i,
    output logic [ADDR_WIDTH-1:0]   sub_addr_o,
    output logic                    sub_we_o,
    output logic [DATA_WIDTH/8-1:0] sub_be_o,
    output logic [DATA_WIDTH-1:0]   sub_wdata_o,
    input  logic                    sub_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   sub_rdata_i,
    output logic                    err_o
);

    mgr_id_t sel;
    mgr_id_t last_gnt;
    mgr_id_t id_head;
    logic    fifo_full;
    logic    fifo_empty;
    logic    handshake;
    logic    resp_pop;

    // Contention goes to the manager that was not granted last.
    always_comb begin
        sel = mgr_id_t'(1'b0);
        if (mgr0_req_i && mgr1_req_i) begin
            sel = ~last_gnt;
        end else if (mgr1_req_i) begin
            sel = mgr_id_t'(1'b1);
        end
    end

    // rst_ni gates the request so nothing leaks out while reset is held.
    assign sub_req_o   = rst_ni & (mgr0_req_i | mgr1_req_i) & ~fifo_full;
    assign sub_addr_o  = sel ? mgr1_addr_i  : mgr0_addr_i;
    assign sub_we_o    = sel ? mgr1_we_i    : mgr0_we_i;
    assign sub_be_o    = sel ? mgr1_be_i    : mgr0_be_i;
    assign sub_wdata_o = sel ? mgr1_wdata_i : mgr0_wdata_i;

    assign handshake  = sub_req_o & sub_gnt_i;
    assign mgr0_gnt_o = handshake & (sel == 1'b0);
    assign mgr1_gnt_o = handshake & (sel == 1'b1);

    assign resp_pop      = sub_rvalid_i & ~fifo_empty;
    assign mgr0_rvalid_o = resp_pop & (id_head == 1'b0);
    assign mgr1_rvalid_o = resp_pop & (id_head == 1'b1);
    assign mgr0_rdata_o  = sub_rdata_i;
    assign mgr1_rdata_o  = sub_rdata_i;

    obi_id_fifo #(
        .WIDTH (1),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push      (handshake),
        .push_data (sel),
        .pop       (resp_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (id_head)
    );

    // A response with nothing outstanding is a protocol violation; it stays flagged.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_gnt <= mgr_id_t'(1'b1);
            err_o    <= 1'b0;
        end else begin
            if (handshake) begin
                last_gnt <= sel;
            end
            if (sub_rvalid_i && fifo_empty) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_obi_mux_2_to_1.sv
// Self-checking bench for obi_mux_2_to_1: queue-based reference model plus directed scenarios.
module tb_obi_mux_2_to_1;

    localparam int MAXO = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;

    localparam logic [AW-1:0] ADDR0  = 32'h8000_0010;
    localparam logic [AW-1:0] ADDR1  = 32'h9000_0020;
    localparam logic [DW-1:0] WDATA0 = 32'h1111_2222;
    localparam logic [DW-1:0] WDATA1 = 32'h3333_4444;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mgr0_req = 1'b0, mgr1_req = 1'b0;
    logic          mgr0_gnt, mgr1_gnt;
    logic [AW-1:0] mgr0_addr = ADDR0, mgr1_addr = ADDR1;
    logic          mgr0_we = 1'b0, mgr1_we = 1'b1;
    logic [BW-1:0] mgr0_be = 4'hF, mgr1_be = 4'h3;
    logic [DW-1:0] mgr0_wdata = WDATA0, mgr1_wdata = WDATA1;
    logic          mgr0_rvalid, mgr1_rvalid;
    logic [DW-1:0] mgr0_rdata, mgr1_rdata;
    logic          sub_req;
    logic          sub_gnt = 1'b0;
    logic [AW-1:0] sub_addr;
    logic          sub_we;
    logic [BW-1:0] sub_be;
    logic [DW-1:0] sub_wdata;
    logic          sub_rvalid = 1'b0;
    logic [DW-1:0] sub_rdata = '0;
    logic          err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    obi_mux_2_to_1 #(
        .MAX_OUTSTANDING (MAXO),
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .mgr0_req_i    (mgr0_req),
        .mgr0_gnt_o    (mgr0_gnt),
        .mgr0_addr_i   (mgr0_addr),
        .mgr0_we_i     (mgr0_we),
        .mgr0_be_i     (mgr0_be),
        .mgr0_wdata_i  (mgr0_wdata),
        .mgr0_rvalid_o (mgr0_rvalid),
        .mgr0_rdata_o  (mgr0_rdata),
        .mgr1_req_i    (mgr1_req),
        .mgr1_gnt_o    (mgr1_gnt),
        .mgr1_addr_i   (mgr1_addr),
        .mgr1_we_i     (mgr1_we),
        .mgr1_be_i     (mgr1_be),
        .mgr1_wdata_i  (mgr1_wdata),
        .mgr1_rvalid_o (mgr1_rvalid),
        .mgr1_rdata_o  (mgr1_rdata),
        .sub_req_o     (sub_req),
        .sub_gnt_i     (sub_gnt),
        .sub_addr_o    (sub_addr),
        .sub_we_o      (sub_we),
        .sub_be_o      (sub_be),
        .sub_wdata_o   (sub_wdata),
        .sub_rvalid_i  (sub_rvalid),
        .sub_rdata_i   (sub_rdata),
        .err_o         (err)
    );

    // Reference model: owners of outstanding transactions, last winner, sticky error.
    int owners[$];
    int mdl_last = 1;
    bit mdl_err  = 1'b0;

    function automatic int exp_sel();
        if (mgr0_req && mgr1_req) return (mdl_last == 0) ? 1 : 0;
        return mgr1_req ? 1 : 0;
    endfunction

    function automatic bit exp_req();
        return rst_n && (mgr0_req || mgr1_req) && (owners.size() < MAXO);
    endfunction

    function automatic bit exp_rvalid(input int id);
        return rst_n && sub_rvalid && (owners.size() > 0) && (owners[0] == id);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owners.delete();
            mdl_last = 1;
            mdl_err  = 1'b0;
        end else begin
            automatic bit hs  = exp_req() && sub_gnt;
            automatic int s   = exp_sel();
            automatic bit emp = (owners.size() == 0);
            if (sub_rvalid && emp) mdl_err = 1'b1;
            if (sub_rvalid && !emp) void'(owners.pop_front());
            if (hs) begin
                owners.push_back(s);
                mdl_last = s;
            end
        end
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        automatic bit r = exp_req();
        automatic int s = exp_sel();
        check_output("sub_req", 64'(sub_req), 64'(r));
        check_output("mgr0_gnt", 64'(mgr0_gnt), 64'(r && sub_gnt && s == 0));
        check_output("mgr1_gnt", 64'(mgr1_gnt), 64'(r && sub_gnt && s == 1));
        check_output("mgr0_rvalid", 64'(mgr0_rvalid), 64'(exp_rvalid(0)));
        check_output("mgr1_rvalid", 64'(mgr1_rvalid), 64'(exp_rvalid(1)));
        check_output("mgr0_rdata", 64'(mgr0_rdata), 64'(sub_rdata));
        check_output("mgr1_rdata", 64'(mgr1_rdata), 64'(sub_rdata));
        check_output("err", 64'(err), 64'(mdl_err));
        if (r) begin
            check_output("sub_addr", 64'(sub_addr), 64'((s == 1) ? ADDR1 : ADDR0));
            check_output("sub_we", 64'(sub_we), 64'((s == 1) ? 1'b1 : 1'b0));
            check_output("sub_be", 64'(sub_be), 64'((s == 1) ? 4'h3 : 4'hF));
            check_output("sub_wdata", 64'(sub_wdata), 64'((s == 1) ? WDATA1 : WDATA0));
        end
    end

    // Drive one cycle of inputs just after the clock edge, then wait to mid-cycle.
    task automatic apply_stimulus(input bit r0, input bit r1, input bit g, input bit rv,
                                  input logic [DW-1:0] rd);
        @(posedge clk);
        #1;
        mgr0_req   = r0;
        mgr1_req   = r1;
        sub_gnt    = g;
        sub_rvalid = rv;
        sub_rdata  = rd;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        mgr0_req = 0; mgr1_req = 0; sub_gnt = 0; sub_rvalid = 0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        // Held in reset: everything quiet.
        @(negedge clk);
        check_output("rst_sub_req", 64'(sub_req), 64'(0));
        check_output("rst_err", 64'(err), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single mgr0 read, response two cycles after the grant.
        apply_stimulus(1, 0, 1, 0, '0);
        check_output("t1_gnt0", 64'(mgr0_gnt), 64'(1));
        check_output("t1_addr", 64'(sub_addr), 64'(32'h8000_0010));
        apply_stimulus(0, 0, 1, 0, '0);
        check_output("t1_gnt0_pulse", 64'(mgr0_gnt), 64'(0));
        apply_stimulus(0, 0, 0, 1, 32'hCAFE_F00D);
        check_output("t1_rvalid0", 64'(mgr0_rvalid), 64'(1));
        check_output("t1_rdata0", 64'(mgr0_rdata), 64'(32'hCAFE_F00D));
        check_output("t1_rvalid1", 64'(mgr1_rvalid), 64'(0));

        // Both requesting with immediate responses: strict alternation from mgr0.
        do_reset();
        apply_stimulus(1, 1, 1, 0, '0);
        check_output("t2_g0_a", 64'({mgr1_gnt, mgr0_gnt}), 64'(2'b01));
        apply_stimulus(1, 1, 1, 1, 32'hA1);
        check_output("t2_g1_a", 64'({mgr1_gnt, mgr0_gnt}), 64'(2'b10));
        check_output("t2_rv_a", 64'({mgr1_rvalid, mgr0_rvalid}), 64'(2'b01));
        apply_stimulus(1, 1, 1, 1, 32'hA2);
        check_output("t2_g0_b", 64'({mgr1_gnt, mgr0_gnt}), 64'(2'b01));
        check_output("t2_rv_b", 64'({mgr1_rvalid, mgr0_rvalid}), 64'(2'b10));
        apply_stimulus(1, 1, 1, 1, 32'hA3);
        check_output("t2_g1_b", 64'({mgr1_gnt, mgr0_gnt}), 64'(2'b10));
        check_output("t2_rv_c", 64'({mgr1_rvalid, mgr0_rvalid}), 64'(2'b01));
        apply_stimulus(0, 0, 0, 1, 32'hA4);
        check_output("t2_rv_d", 64'({mgr1_rvalid, mgr0_rvalid}), 64'(2'b10));

        // Give mgr0 the last grant so mgr1 is favoured under contention.
        apply_stimulus(1, 0, 1, 0, '0);
        apply_stimulus(0, 0, 0, 1, 32'hB0);

        // Stalled subordinate: mgr1's address held until its grant.
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(0, 1, 0, 0, '0);
            check_output("t3_hold_addr", 64'(sub_addr), 64'(32'h9000_0020));
            check_output("t3_no_gnt", 64'(mgr1_gnt), 64'(0));
        end
        apply_stimulus(1, 1, 0, 0, '0);
        check_output("t3_still_mgr1", 64'(sub_addr), 64'(32'h9000_0020));
        apply_stimulus(1, 1, 1, 0, '0);
        check_output("t3_g1_first", 64'({mgr1_gnt, mgr0_gnt}), 64'(2'b10));
        apply_stimulus(1, 0, 1, 0, '0);
        check_output("t3_g0_next", 64'({mgr1_gnt, mgr0_gnt}), 64'(2'b01));

        // Two outstanding: full, no bypass on the popping cycle, resume after.
        apply_stimulus(1, 1, 1, 0, '0);
        check_output("t4_full_req", 64'(sub_req), 64'(0));
        check_output("t4_full_gnt", 64'({mgr1_gnt, mgr0_gnt}), 64'(0));
        apply_stimulus(1, 1, 1, 1, 32'hC1);
        check_output("t4_nobypass", 64'(sub_req), 64'(0));
        check_output("t4_rv1", 64'(mgr1_rvalid), 64'(1));
        apply_stimulus(1, 1, 1, 0, '0);
        check_output("t4_resume", 64'({mgr1_gnt, mgr0_gnt}), 64'(2'b10));

        // Asynchronous reset with two outstanding, requests still high.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_output("t6_async_req", 64'(sub_req), 64'(0));
        check_output("t6_async_gnt", 64'({mgr1_gnt, mgr0_gnt}), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_output("t6_mgr0_first", 64'({mgr1_gnt, mgr0_gnt}), 64'(2'b01));
        apply_stimulus(0, 0, 0, 1, 32'hD1);
        check_output("t6_rv0", 64'(mgr0_rvalid), 64'(1));

        // Stray response with nothing outstanding.
        do_reset();
        apply_stimulus(0, 0, 0, 1, 32'hE1);
        check_output("t5_no_rvalid", 64'({mgr1_rvalid, mgr0_rvalid}), 64'(0));
        check_output("t5_err_pre", 64'(err), 64'(0));
        apply_stimulus(0, 0, 0, 0, '0);
        check_output("t5_err_set", 64'(err), 64'(1));
        apply_stimulus(1, 0, 1, 0, '0);
        apply_stimulus(0, 0, 0, 1, 32'hE2);
        check_output("t5_err_held", 64'(err), 64'(1));
        do_reset();
        @(negedge clk);
        check_output("t5_err_clear", 64'(err), 64'(0));

        apply_stimulus(0, 0, 0, 0, '0);
        $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
